// File: rtl/player_bullet_if.sv
// Player/bullet control bundle: button and hit inputs toward the block,
// cannon/bullet position, shot status and score back from it.
interface player_bullet_if #(
  parameter int COLS = 20,
  parameter int ROWS = 8
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  logic          fire;
  logic          move_left;
  logic          move_right;
  logic          hit;
  logic [XW-1:0] player_x;
  logic [XW-1:0] bullet_x;
  logic [YW-1:0] bullet_y;
  logic          bullet_active;
  logic          shot_done;
  logic [7:0]    score;

  modport master (
    output fire, move_left, move_right, hit,
    input  player_x, bullet_x, bullet_y, bullet_active, shot_done, score
  );

  modport slave (
    input  fire, move_left, move_right, hit,
    output player_x, bullet_x, bullet_y, bullet_active, shot_done, score
  );
endinterface

// File: rtl/player_bullet.sv
// Player cannon movement and single-bullet flight control for the invaders playfield.
// Define PLAYER_BULLET_SCORE_EN to build the saturating hit-score counter.
module player_bullet #(
  parameter int COLS     = 20,
  parameter int ROWS     = 8,
  parameter int STEP_DIV = 4,
  parameter int MOVE_DIV = 8
) (
  input  logic           clk,
  input  logic           reset,
  player_bullet_if.slave bus
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DIV - 1);
  localparam logic [XW-1:0] X_MAX     = XW'(COLS - 1);
  localparam logic [XW-1:0] X_HOME    = XW'(COLS / 2);
  localparam logic [YW-1:0] Y_TOP     = YW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FLY, RETIRE} state_t;

  state_t        state_reg, state_next;
  logic          fire_prev_reg;
  logic [SW-1:0] step_reg, step_next;
  logic [MW-1:0] move_reg, move_next;
  logic [XW-1:0] player_x_reg, player_x_next;
  logic [XW-1:0] bullet_x_reg, bullet_x_next;
  logic [YW-1:0] bullet_y_reg, bullet_y_next;
  logic          active_reg, active_next;
  logic          shot_done_reg, shot_done_next;
  logic          fire_edge;

  assign fire_edge = bus.fire & ~fire_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      fire_prev_reg <= 1'b1;  // a button held through reset must be released first
      step_reg      <= '0;
      move_reg      <= '0;
      player_x_reg  <= X_HOME;
      bullet_x_reg  <= '0;
      bullet_y_reg  <= '0;
      active_reg    <= 1'b0;
      shot_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fire_prev_reg <= bus.fire;
      step_reg      <= step_next;
      move_reg      <= move_next;
      player_x_reg  <= player_x_next;
      bullet_x_reg  <= bullet_x_next;
      bullet_y_reg  <= bullet_y_next;
      active_reg    <= active_next;
      shot_done_reg <= shot_done_next;
    end
  end

  // Bullet flight: outputs for RETIRE are set on the edge entering it so
  // shot_done is high exactly while the FSM sits in RETIRE.
  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    bullet_x_next  = bullet_x_reg;
    bullet_y_next  = bullet_y_reg;
    active_next    = active_reg;
    shot_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fire_edge) begin
          bullet_x_next = player_x_reg;
          bullet_y_next = YW'(1);
          active_next   = 1'b1;
          step_next     = '0;
          state_next    = FLY;
        end
      end
      FLY: begin
        if (bus.hit) begin
          active_next    = 1'b0;
          shot_done_next = 1'b1;
          state_next     = RETIRE;
        end else if (step_reg == STEP_LAST) begin
          step_next = '0;
          if (bullet_y_reg == Y_TOP) begin
            active_next    = 1'b0;
            shot_done_next = 1'b1;
            state_next     = RETIRE;
          end else begin
            bullet_y_next = bullet_y_reg + YW'(1);
          end
        end else begin
          step_next = step_reg + SW'(1);
        end
      end
      RETIRE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cannon movement runs on its own divider, unaffected by the bullet.
  always_comb begin
    player_x_next = player_x_reg;
    move_next     = move_reg + MW'(1);
    if (move_reg == MOVE_LAST) begin
      move_next = '0;
      if (bus.move_left && !bus.move_right && player_x_reg != '0)
        player_x_next = player_x_reg - XW'(1);
      else if (bus.move_right && !bus.move_left && player_x_reg < X_MAX)
        player_x_next = player_x_reg + XW'(1);
    end
  end

  assign bus.player_x      = player_x_reg;
  assign bus.bullet_x      = bullet_x_reg;
  assign bus.bullet_y      = bullet_y_reg;
  assign bus.bullet_active = active_reg;
  assign bus.shot_done     = shot_done_reg;

`ifdef PLAYER_BULLET_SCORE_EN
  // Only the score cares how a shot ended, so the hit flag lives here.
  logic       hit_flag_reg;
  logic [7:0] score_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_flag_reg <= 1'b0;
      score_reg    <= '0;
    end else begin
      if (state_reg == FLY && state_next == RETIRE)
        hit_flag_reg <= bus.hit;
      if (state_reg == RETIRE && hit_flag_reg && score_reg != 8'hFF)
        score_reg <= score_reg + 8'd1;
    end
  end

  assign bus.score = score_reg;
`else
  assign bus.score = 8'd0;
`endif
endmodule

// File: doc/player_bullet.md
PLAYER_BULLET -- requirements
Module: player_bullet

Interface
REQ-001 The module SHALL have parameter COLS, default 20, giving the number of playfield columns; it matches the invader bitmap width.
REQ-002 The module SHALL have parameter ROWS, default 8, giving the number of playfield rows; row 0 is the player row and row ROWS-1 is the top row.
REQ-003 The module SHALL have parameter STEP_DIV, default 4, giving the number of clk cycles per bullet row advance (minimum 1).
REQ-004 The module SHALL have parameter MOVE_DIV, default 8, giving the number of clk cycles per player column move (minimum 1).
REQ-005 Port clk: input, 1 bit, rising-edge clock.
REQ-006 Port reset: input, 1 bit, synchronous, active-high reset.
REQ-007 Port fire: input, 1 bit, level fire button; only a rising edge launches a shot.
REQ-008 Port move_left: input, 1 bit, level request to move the player left.
REQ-009 Port move_right: input, 1 bit, level request to move the player right.
REQ-010 Port hit: input, 1 bit, driven by the invader block; it is high when the current bullet_x/bullet_y overlaps a live invader.
REQ-011 Port player_x: output, $clog2(COLS) bits, player cannon column.
REQ-012 Port bullet_x: output, $clog2(COLS) bits, bullet column.
REQ-013 Port bullet_y: output, $clog2(ROWS) bits, bullet row.
REQ-014 Port bullet_active: output, 1 bit, high while a bullet is in flight; bullet_x/bullet_y are valid only while it is high.
REQ-015 Port shot_done: output, 1 bit, one-cycle pulse when a shot retires by hit or by miss.
REQ-016 Port score: output, 8 bits, count of confirmed hits.

Function
REQ-017 The block SHALL implement states IDLE, FLY and RETIRE, encoded in one registered state variable.
REQ-018 A fire rising edge is fire=1 while fire_prev=0; fire_prev SHALL be registered every cycle.
REQ-019 In IDLE, a fire rising edge SHALL register bullet_x<=player_x, bullet_y<=1, bullet_active<=1, clear the step counter and go to FLY; all outputs are registered, so the response appears on the next edge.
REQ-020 In FLY with hit=1, the block SHALL go to RETIRE with hit_flag=1; hit takes priority over a row advance in the same cycle.
REQ-021 In FLY with hit=0, the step counter SHALL increment; at STEP_DIV-1 it wraps to 0 and then:
- if bullet_y==ROWS-1, go to RETIRE with hit_flag=0 (miss);
- otherwise, bullet_y increments by 1.
REQ-022 In RETIRE, the block SHALL for exactly one cycle:
- drive bullet_active=0 and shot_done=1;
- increment score when hit_flag=1, saturating at 255;
- return to IDLE.
REQ-023 hit SHALL be ignored in IDLE and RETIRE.
REQ-024 A fire edge in FLY or RETIRE SHALL be ignored and not queued.
REQ-025 The move counter SHALL run continuously and wrap at MOVE_DIV-1; on each wrap:
- move_left only and player_x>0: decrement player_x;
- move_right only and player_x<COLS-1: increment player_x;
- both or neither: hold.
REQ-026 Player movement SHALL be independent of bullet state; bullet_x is latched at launch and does not track the player.
REQ-027 bullet_x and bullet_y SHALL hold their last values while bullet_active=0.

Reset
REQ-028 On reset=1 at a clk edge, the block SHALL set:
- state=IDLE;
- player_x=COLS/2 (10 by default);
- bullet_x=0, bullet_y=0, bullet_active=0, shot_done=0;
- score=0;
- step and move counters=0, hit_flag=0;
- fire_prev=1, so a fire held through reset does not launch until released and re-pressed.
REQ-029 Reset asserted mid-flight SHALL abort the shot without a shot_done pulse and without a score change.

Configuration
REQ-030 With PLAYER_BULLET_SCORE_EN defined, the score counter SHALL be implemented as in REQ-022.
REQ-031 Without PLAYER_BULLET_SCORE_EN, score SHALL be tied to 8'd0 and no score register shall exist; all other behaviour is unchanged.

Verification
REQ-032 Miss: player_x=10, fire edge, hit=0 held → bullet_active=1 and bullet_x=10, bullet_y=1 on the next cycle; bullet_y rises by 1 every 4 cycles up to 7; 4 cycles after reaching 7, shot_done pulses once, bullet_active=0 and score stays 0.
REQ-033 Hit: fire, then hit=1 for one cycle when bullet_y=3 → RETIRE next cycle, bullet_y stays 3, shot_done pulses once and score=1 (0 with the macro undefined).
REQ-034 Edge detect: fire held high for 100 cycles → exactly one shot is launched; a second fire edge during FLY produces no second shot.
REQ-035 Movement: move_left held from player_x=10 with MOVE_DIV=8 → player_x reaches 0 after 80 cycles and stays at 0; both buttons held → player_x constant.
REQ-036 Reset: reset asserted at bullet_y=5 → next cycle bullet_active=0, shot_done=0, player_x=10, score=0; with fire still held after reset release, no launch occurs until fire goes low and then high again.
